pipe_stage_buf: RTL

//  Generic inter-stage pipeline register with valid/ready handshake, flush-to-bubble and optional skid slot.

---
 rtl/pipe_stage_buf_pkg.sv | 15 +
 rtl/pipe_stage_buf_if.sv | 16 +
 rtl/pipe_stage_buf_slot.sv | 39 +++
 rtl/pipe_stage_buf.sv | 75 +++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared widths and helpers for the inter-stage pipeline registers (IF/ID .. ME/WB).
package pipe_stage_buf_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;

    // alu_result, rs2_data, pc_plus4, rd_addr
    localparam int unsigned STAGE_DATA_W = DATA_WIDTH * 3 + REG_ADDR_WIDTH;
    localparam int unsigned STAGE_CTRL_W = 8;

    function automatic logic [1:0] occ_count(input logic main_valid, input logic skid_valid);
        return {1'b0, main_valid} + {1'b0, skid_valid};
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready stream carrying a DATA and a CTRL payload between pipeline stages.
interface pipe_stage_buf_if
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned DATA_W = STAGE_DATA_W,
    parameter int unsigned CTRL_W = STAGE_CTRL_W
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);

endinterface

// File: rtl/pipe_stage_buf_slot.sv
// One valid+data+ctrl register. Clear beats load; clear zeroes ctrl but keeps data.
module pipe_stage_buf_slot #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic [CTRL_W-1:0] load_ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= load_data_i;
            ctrl_q  <= load_ctrl_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready, flush-to-bubble and an optional skid slot.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned DATA_W = STAGE_DATA_W,
    parameter int unsigned CTRL_W = STAGE_CTRL_W,
    parameter int unsigned SKID   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    pipe_stage_buf_if.slave        up,
    pipe_stage_buf_if.master       dn,
    output logic [1:0]             occ
);
    logic              m_valid, s_valid;
    logic [DATA_W-1:0] m_data, s_data, m_src_data;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_src_ctrl;
    logic              in_fire, out_fire, m_free, m_load, m_clr;

    assign out_fire = m_valid & dn.ready;
    assign in_fire  = up.valid & up.ready;
    assign m_free   = ~m_valid | out_fire;

    // A waiting skid entry always goes to main before any new input, preserving order.
    assign m_load     = m_free & (s_valid | in_fire);
    assign m_clr      = flush | (m_free & ~s_valid & ~in_fire);
    assign m_src_data = s_valid ? s_data : up.data;
    assign m_src_ctrl = s_valid ? s_ctrl : up.ctrl;

    pipe_stage_buf_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (m_clr),
        .load_i      (m_load),
        .load_data_i (m_src_data),
        .load_ctrl_i (m_src_ctrl),
        .valid_o     (m_valid),
        .data_o      (m_data),
        .ctrl_o      (m_ctrl)
    );

    if (SKID != 0) begin : g_skid
        logic s_load, s_clr;

        assign s_load = m_valid & ~dn.ready & in_fire;
        assign s_clr  = flush | (m_free & s_valid);

        pipe_stage_buf_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
            .clk         (clk),
            .rst_n       (rst_n),
            .clr_i       (s_clr),
            .load_i      (s_load),
            .load_data_i (up.data),
            .load_ctrl_i (up.ctrl),
            .valid_o     (s_valid),
            .data_o      (s_data),
            .ctrl_o      (s_ctrl)
        );

        // Registered ready: no combinational path from dn.ready.
        assign up.ready = ~s_valid;
    end else begin : g_no_skid
        assign s_valid  = 1'b0;
        assign s_data   = '0;
        assign s_ctrl   = '0;
        assign up.ready = ~m_valid | dn.ready;
    end

    assign dn.valid = m_valid;
    assign dn.data  = m_data;
    assign dn.ctrl  = m_ctrl;
    assign occ      = occ_count(m_valid, s_valid);

endmodule
